// File: rtl/apb_adder_slave.sv
// APB3 completer holding two 8-bit operands, their registered sum/carry and a write counter.
// Optional error reporting on pslverr_o is enabled by defining APB_ADDER_SLAVE_PSLVERR_EN.
module apb_adder_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h00D0_AD00,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [7:0]  pwdata_i,
    output logic [7:0]  prdata_o,
    output logic        pready_o,
    output logic        pslverr_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic        write_reg;
    logic [7:0]  wdata_reg;
    logic [7:0]  sum_reg;
    logic        carry_reg;
    logic [7:0]  wcnt_reg;
    logic [7:0]  operand [2];

    logic [31:0] offset;
    logic        in_range;
    logic        bad_access;
    logic        done;
    logic        commit;
    logic        write_ok;
    logic [7:0]  read_value;

    // All decode works on the latched address, never on paddr_i.
    assign offset     = addr_reg - BASE_ADDR;
    assign in_range   = (offset < 32'd5);
    assign bad_access = !in_range || (write_reg && (offset >= 32'd2));
    assign done       = (state_reg == ST_ACCESS) && (cnt_reg == 4'd0);
    assign commit     = done && psel_i && penable_i;
    assign write_ok   = commit && write_reg && !bad_access;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 32'd0;
            write_reg <= 1'b0;
            wdata_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (psel_i && !penable_i) begin
                        addr_reg  <= paddr_i;
                        write_reg <= pwrite_i;
                        wdata_reg <= pwdata_i;
                        cnt_reg   <= 4'(WAIT_CYCLES);
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Dropping psel aborts at any point; leaving access never accepts a new setup.
                    if (!psel_i) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else if (penable_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_operand
            logic [7:0] value_reg;
            always_ff @(posedge pclk) begin
                if (preset) begin
                    value_reg <= 8'd0;
                end else if (write_ok && (offset[2:0] == 3'(gi))) begin
                    value_reg <= wdata_reg;
                end
            end
            assign operand[gi] = value_reg;
        end
    endgenerate

    // Sum/carry reload every cycle, so they trail an operand write by one cycle.
    always_ff @(posedge pclk) begin
        if (preset) begin
            sum_reg   <= 8'd0;
            carry_reg <= 1'b0;
            wcnt_reg  <= 8'd0;
        end else begin
            {carry_reg, sum_reg} <= {1'b0, operand[0]} + {1'b0, operand[1]};
            if (write_ok) begin
                wcnt_reg <= wcnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        read_value = 8'h00;
        case (offset[2:0])
            3'd0:    read_value = operand[0];
            3'd1:    read_value = operand[1];
            3'd2:    read_value = sum_reg;
            3'd3:    read_value = {7'b0, carry_reg};
            3'd4:    read_value = wcnt_reg;
            default: read_value = 8'h00;
        endcase
    end

    assign pready_o = done;
    assign prdata_o = (done && !write_reg && in_range) ? read_value : 8'h00;

`ifdef APB_ADDER_SLAVE_PSLVERR_EN
    assign pslverr_o = done && bad_access;
`else
    assign pslverr_o = 1'b0;
`endif

endmodule
